// File: rtl/sdram_pkg.sv
// Shared command, opcode and FSM state types for the SDRAM command dispatcher.
package sdram_pkg;

    // Command address field is sized for the widest supported ADDR_WIDTH.
    localparam int CMD_ADDR_W = 32;

    localparam logic READ_CMD  = 1'b0;
    localparam logic WRITE_CMD = 1'b1;

    typedef struct packed {
        logic                  rw;
        logic [CMD_ADDR_W-1:0] addr;
        logic                  auto_precharge_en;
    } sdram_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WR_DATA = 2'd2,
        RD_WAIT = 2'd3
    } disp_state_t;

endpackage

// File: rtl/sdram_rd_fifo.sv
// First-word-fall-through read data FIFO; a push while full is accepted only
// when a pop happens in the same cycle.
module sdram_rd_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  do_pop;
    logic                  do_push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sdram_cmd_dispatcher.sv
// Turns arbiter commands into controller request/ack handshakes and moves the
// burst data. Optional burst statistics ports: SDRAM_DISPATCH_STATS_EN.
module sdram_cmd_dispatcher
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  sdram_cmd_t            cmd_data,
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ctrl_req,
    input  logic                  ctrl_ack,
    output logic                  ctrl_rw,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic                  ctrl_ap,
    input  logic                  ctrl_wdata_req,
    output logic [DATA_WIDTH-1:0] ctrl_wdata,
    input  logic                  ctrl_rdata_valid,
    input  logic [DATA_WIDTH-1:0] ctrl_rdata,
    output logic                  rd_data_valid,
    input  logic                  rd_data_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic [1:0]            err,
    output disp_state_t           dbg_state
`ifdef SDRAM_DISPATCH_STATS_EN
    ,
    output logic [31:0]           stat_rd_bursts,
    output logic [31:0]           stat_wr_bursts
`endif
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and the controller read stream has no ready.
    localparam int DEPTH = 2 * BURST_LEN;
    localparam int BW    = $clog2(BURST_LEN);
    localparam int CW    = $clog2(DEPTH + 1);

    disp_state_t           state_q;
    logic [BW-1:0]         beat_q;
    logic [BW-1:0]         pop_cnt_q;
    logic [1:0]            err_q;
    logic                  ctrl_req_q;
    logic                  ctrl_rw_q;
    logic [ADDR_WIDTH-1:0] ctrl_addr_q;
    logic                  ctrl_ap_q;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_free;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic          in_wr;
    logic          in_rd;
    logic          last_beat;
    logic          cmd_fire;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^cmd_data.addr;

    assign in_wr     = (state_q == WR_DATA);
    assign in_rd     = (state_q == RD_WAIT);
    assign last_beat = (beat_q == BW'(BURST_LEN - 1));
    assign fifo_free = CW'(DEPTH) - fifo_count;

    // Reads are only admitted when a whole burst is guaranteed to fit.
    assign cmd_ready = !rst && (state_q == IDLE) &&
                       (cmd_data.rw == WRITE_CMD || fifo_free >= CW'(BURST_LEN));
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign wr_data_ready = in_wr && ctrl_wdata_req;
    assign ctrl_wdata    = (in_wr && wr_data_valid) ? wr_data : '0;

    assign rd_data_valid = !fifo_empty;
    assign fifo_pop      = rd_data_valid && rd_data_ready;
    assign fifo_push     = in_rd && ctrl_rdata_valid && (!fifo_full || fifo_pop);
    assign rd_last       = rd_data_valid && (pop_cnt_q == BW'(BURST_LEN - 1));

    assign ctrl_req  = ctrl_req_q;
    assign ctrl_rw   = ctrl_rw_q;
    assign ctrl_addr = ctrl_addr_q;
    assign ctrl_ap   = ctrl_ap_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

    sdram_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (ctrl_rdata),
        .pop       (fifo_pop),
        .pop_data  (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            pop_cnt_q   <= '0;
            err_q       <= '0;
            ctrl_req_q  <= 1'b0;
            ctrl_rw_q   <= READ_CMD;
            ctrl_addr_q <= '0;
            ctrl_ap_q   <= 1'b0;
        end else begin
            if (fifo_pop) begin
                pop_cnt_q <= pop_cnt_q + BW'(1);
            end
            if (ctrl_rdata_valid && !fifo_push) begin
                err_q[1] <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        ctrl_rw_q   <= cmd_data.rw;
                        ctrl_addr_q <= cmd_data.addr[ADDR_WIDTH-1:0];
                        ctrl_ap_q   <= cmd_data.auto_precharge_en;
                        ctrl_req_q  <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ctrl_ack) begin
                        ctrl_req_q <= 1'b0;
                        beat_q     <= '0;
                        state_q    <= (ctrl_rw_q == WRITE_CMD) ? WR_DATA : RD_WAIT;
                    end
                end
                WR_DATA: begin
                    // An underrun beat still counts so the burst stays framed.
                    if (ctrl_wdata_req) begin
                        if (!wr_data_valid) begin
                            err_q[0] <= 1'b1;
                        end
                        beat_q <= beat_q + BW'(1);
                        if (last_beat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                RD_WAIT: begin
                    if (ctrl_rdata_valid) begin
                        beat_q <= beat_q + BW'(1);
                        if (last_beat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SDRAM_DISPATCH_STATS_EN
    logic [31:0] stat_rd_q;
    logic [31:0] stat_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            if (in_rd && ctrl_rdata_valid && last_beat && stat_rd_q != '1) begin
                stat_rd_q <= stat_rd_q + 32'd1;
            end
            if (in_wr && ctrl_wdata_req && last_beat && stat_wr_q != '1) begin
                stat_wr_q <= stat_wr_q + 32'd1;
            end
        end
    end

    assign stat_rd_bursts = stat_rd_q;
    assign stat_wr_bursts = stat_wr_q;
`endif

endmodule

// File: tb/tb_sdram_cmd_dispatcher.sv
// Self-checking bench for sdram_cmd_dispatcher: vector table of bursts, read
// data scoreboard, and directed sequences for back-pressure, underrun and reset.
module tb_sdram_cmd_dispatcher;
    import sdram_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    sdram_cmd_t    cmd_data;
    logic          wr_data_valid;
    logic          wr_data_ready;
    logic [DW-1:0] wr_data;
    logic          ctrl_req;
    logic          ctrl_ack;
    logic          ctrl_rw;
    logic [AW-1:0] ctrl_addr;
    logic          ctrl_ap;
    logic          ctrl_wdata_req;
    logic [DW-1:0] ctrl_wdata;
    logic          ctrl_rdata_valid;
    logic [DW-1:0] ctrl_rdata;
    logic          rd_data_valid;
    logic          rd_data_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic [1:0]    err;
    disp_state_t   dbg_state;
`ifdef SDRAM_DISPATCH_STATS_EN
    logic [31:0]   stat_rd_bursts;
    logic [31:0]   stat_wr_bursts;
`endif

    sdram_cmd_dispatcher #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_data         (cmd_data),
        .wr_data_valid    (wr_data_valid),
        .wr_data_ready    (wr_data_ready),
        .wr_data          (wr_data),
        .ctrl_req         (ctrl_req),
        .ctrl_ack         (ctrl_ack),
        .ctrl_rw          (ctrl_rw),
        .ctrl_addr        (ctrl_addr),
        .ctrl_ap          (ctrl_ap),
        .ctrl_wdata_req   (ctrl_wdata_req),
        .ctrl_wdata       (ctrl_wdata),
        .ctrl_rdata_valid (ctrl_rdata_valid),
        .ctrl_rdata       (ctrl_rdata),
        .rd_data_valid    (rd_data_valid),
        .rd_data_ready    (rd_data_ready),
        .rd_data          (rd_data),
        .rd_last          (rd_last),
        .busy             (busy),
        .err              (err),
        .dbg_state        (dbg_state)
`ifdef SDRAM_DISPATCH_STATS_EN
        ,
        .stat_rd_bursts   (stat_rd_bursts),
        .stat_wr_bursts   (stat_wr_bursts)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW:0]   exp_q[$];
    int            push_idx = 0;
    logic [DW:0]   mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Every BL-th word handed to the controller side closes a burst.
    task automatic push_exp(input logic [DW-1:0] d);
        exp_q.push_back({((push_idx % BL) == BL - 1), d});
        push_idx++;
    endtask

    // A pop happens on the next rising edge when valid && ready at the falling edge.
    always @(negedge clk) begin
        if (!rst && rd_data_valid && rd_data_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no word", rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(mon_e[DW-1:0]));
                check("rd_last", 64'(rd_last), 64'(mon_e[DW]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_data.rw = WRITE_CMD;
        tick();
        tick();
        check("cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        push_idx = 0;
        #1;
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_ctrl_req", 64'(ctrl_req), 64'd0);
        check("rst_wr_ready", 64'(wr_data_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_data_valid), 64'd0);
        check("rst_rd_last", 64'(rd_last), 64'd0);
        check("rst_ctrl_addr", 64'(ctrl_addr), 64'd0);
        check("rst_ctrl_wdata", 64'(ctrl_wdata), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
    endtask

    task automatic issue_cmd(input logic rw, input logic [AW-1:0] addr, input logic ap,
                             input int ack_dly);
        int guard;
        guard = 0;
        cmd_data.rw = rw;
        cmd_data.addr = 32'(addr);
        cmd_data.auto_precharge_en = ap;
        cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_ready_timeout: got 0, expected 1 within 200 cycles");
            cmd_valid = 1'b0;
            return;
        end
        tick();
        cmd_valid = 1'b0;
        check("issue_req", 64'(ctrl_req), 64'd1);
        check("issue_addr", 64'(ctrl_addr), 64'(addr));
        check("issue_rw", 64'(ctrl_rw), 64'(rw));
        check("issue_ap", 64'(ctrl_ap), 64'(ap));
        check("issue_busy", 64'(busy), 64'd1);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            check("hold_req", 64'(ctrl_req), 64'd1);
            check("hold_addr", 64'(ctrl_addr), 64'(addr));
        end
        ctrl_ack = 1'b1;
        tick();
        ctrl_ack = 1'b0;
        check("req_after_ack", 64'(ctrl_req), 64'd0);
        check("state_after_ack", 64'(dbg_state), 64'(rw == WRITE_CMD ? WR_DATA : RD_WAIT));
    endtask

    task automatic write_burst(input logic [DW-1:0] base, input int drop, input int gap);
        logic [DW-1:0] w;
        for (int b = 0; b < BL; b++) begin
            if (b == gap) begin
                ctrl_wdata_req = 1'b0;
                wr_data_valid = 1'b1;
                wr_data = 16'hDEAD;
                #1;
                check("wr_ready_gap", 64'(wr_data_ready), 64'd0);
                tick();
            end
            w = base + DW'(b);
            ctrl_wdata_req = 1'b1;
            wr_data_valid = (b != drop);
            wr_data = w;
            #1;
            check("wr_ready", 64'(wr_data_ready), 64'd1);
            check("ctrl_wdata", 64'(ctrl_wdata), (b == drop) ? 64'd0 : 64'(w));
            tick();
        end
        ctrl_wdata_req = 1'b0;
        wr_data_valid = 1'b0;
        check("wr_done_state", 64'(dbg_state), 64'(IDLE));
    endtask

    task automatic read_burst(input logic [DW-1:0] base, input int gap);
        for (int b = 0; b < BL; b++) begin
            if (b == gap) begin
                ctrl_rdata_valid = 1'b0;
                tick();
            end
            ctrl_rdata_valid = 1'b1;
            ctrl_rdata = base + DW'(b);
            push_exp(base + DW'(b));
            tick();
        end
        ctrl_rdata_valid = 1'b0;
        check("rd_done_state", 64'(dbg_state), 64'(IDLE));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        rd_data_ready = 1'b1;
        while ((exp_q.size() != 0 || rd_data_valid) && guard < 300) begin
            tick();
            guard++;
        end
        if (exp_q.size() != 0 || rd_data_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d words left, expected 0", exp_q.size());
        end
    endtask

    task automatic pop_words(input int n);
        rd_data_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
        end
        rd_data_ready = 1'b0;
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic          ap;
        int            ack_dly;
        logic [DW-1:0] base;
        int            drop;
        int            gap;
        logic [1:0]    exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        cmd_valid = 1'b0;
        cmd_data = '0;
        wr_data_valid = 1'b0;
        wr_data = '0;
        ctrl_ack = 1'b0;
        ctrl_wdata_req = 1'b0;
        ctrl_rdata_valid = 1'b0;
        ctrl_rdata = '0;
        rd_data_ready = 1'b0;
        rst = 1'b1;

        vecs[0] = '{READ_CMD,  24'h000100, 1'b0, 3, 16'h00A0, -1, -1, 2'b00};
        vecs[1] = '{WRITE_CMD, 24'h000200, 1'b0, 0, 16'h0010, -1, -1, 2'b00};
        vecs[2] = '{WRITE_CMD, 24'h0003F8, 1'b1, 1, 16'h1230, -1,  2, 2'b00};
        vecs[3] = '{READ_CMD,  24'hFFFFF8, 1'b1, 0, 16'hC0C0, -1,  5, 2'b00};
        vecs[4] = '{READ_CMD,  24'h000008, 1'b0, 2, 16'h0000, -1, -1, 2'b00};
        vecs[5] = '{WRITE_CMD, 24'h000300, 1'b0, 1, 16'h0010,  4, -1, 2'b01};
        vecs[4].addr = AW'($urandom_range(0, 24'hFFFFFF));
        vecs[4].base = DW'($urandom_range(0, 16'hFFFF));
        vecs[4].ack_dly = $urandom_range(0, 4);
        vecs[4].gap = $urandom_range(0, BL - 1);

        do_reset();

        rd_data_ready = 1'b1;
        foreach (vecs[i]) begin
            issue_cmd(vecs[i].rw, vecs[i].addr, vecs[i].ap, vecs[i].ack_dly);
            if (vecs[i].rw == WRITE_CMD) begin
                write_burst(vecs[i].base, vecs[i].drop, vecs[i].gap);
            end else begin
                read_burst(vecs[i].base, vecs[i].gap);
                drain();
            end
            check("vec_err", 64'(err), 64'(vecs[i].exp_err));
        end

        // Underrun error is sticky until reset.
        tick();
        tick();
        check("err0_sticky", 64'(err), 64'b01);
        do_reset();

        // Back-pressure: two bursts fill the FIFO, a third read must wait for 8 free.
        rd_data_ready = 1'b0;
        issue_cmd(READ_CMD, 24'h000400, 1'b0, 1);
        read_burst(16'h5000, -1);
        issue_cmd(READ_CMD, 24'h000408, 1'b0, 0);
        read_burst(16'h5100, -1);
        cmd_data.rw = READ_CMD;
        #1;
        check("full_cmd_ready_rd", 64'(cmd_ready), 64'd0);
        cmd_data.rw = WRITE_CMD;
        #1;
        check("full_cmd_ready_wr", 64'(cmd_ready), 64'd1);
        cmd_data.rw = READ_CMD;
        tick();
        check("full_hold", 64'(cmd_ready), 64'd0);
        pop_words(1);
        check("ready_after_1pop", 64'(cmd_ready), 64'd0);
        pop_words(6);
        check("ready_after_7pop", 64'(cmd_ready), 64'd0);
        pop_words(1);
        check("ready_after_8pop", 64'(cmd_ready), 64'd1);
        rd_data_ready = 1'b1;
        issue_cmd(READ_CMD, 24'h000410, 1'b1, 0);
        read_burst(16'h5200, 3);
        drain();
        check("bp_err", 64'(err), 64'd0);

        // Stray controller read data in IDLE is dropped and flagged.
        ctrl_rdata_valid = 1'b1;
        ctrl_rdata = 16'hBEEF;
        tick();
        ctrl_rdata_valid = 1'b0;
        #1;
        check("stray_rd_valid", 64'(rd_data_valid), 64'd0);
        check("stray_err", 64'(err), 64'b10);
        check("stray_state", 64'(dbg_state), 64'(IDLE));

        // Reset in the middle of a read burst flushes everything.
        rd_data_ready = 1'b0;
        issue_cmd(READ_CMD, 24'h000500, 1'b0, 0);
        for (int b = 0; b < 3; b++) begin
            ctrl_rdata_valid = 1'b1;
            ctrl_rdata = 16'h6600 + DW'(b);
            push_exp(16'h6600 + DW'(b));
            tick();
        end
        check("mid_rd_valid", 64'(rd_data_valid), 64'd1);
        ctrl_rdata_valid = 1'b1;
        ctrl_rdata = 16'h6603;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ctrl_rdata_valid = 1'b0;
        exp_q.delete();
        push_idx = 0;
        #1;
        check("midrst_state", 64'(dbg_state), 64'(IDLE));
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rd_valid", 64'(rd_data_valid), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_rd_data", 64'(rd_data), 64'd0);

        // Pop counter restarts after reset: rd_last on the 8th word again.
        rd_data_ready = 1'b1;
        issue_cmd(READ_CMD, 24'h000600, 1'b0, 2);
        read_burst(16'h7700, -1);
        drain();
        check("final_err", 64'(err), 64'd0);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_dispatcher.md
SDRAM_CMD_DISPATCHER -- requirements
Module: sdram_cmd_dispatcher

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 24, meaning the SDRAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the data word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 8, meaning the words per burst (power of two, 2..64).
REQ-004 The block SHALL have port clk  in  1  meaning the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst  in  1  meaning the synchronous, active-high reset.
REQ-006 The block SHALL have ports cmd_valid in 1, cmd_ready out 1 and cmd_data in sdram_cmd_t, meaning the command stream from the arbiter/command FIFO.
REQ-007 The block SHALL have ports wr_data_valid in 1, wr_data_ready out 1 and wr_data in DATA_WIDTH, meaning the write payload from the writer.
REQ-008 The block SHALL have ports ctrl_req out 1, ctrl_ack in 1, ctrl_rw out 1, ctrl_addr out ADDR_WIDTH and ctrl_ap out 1, meaning the controller command handshake.
REQ-009 The block SHALL have ports ctrl_wdata_req in 1 and ctrl_wdata out DATA_WIDTH, meaning the controller pulling one write word per cycle.
REQ-010 The block SHALL have ports ctrl_rdata_valid in 1 and ctrl_rdata in DATA_WIDTH, meaning the controller's non-stallable read data.
REQ-011 The block SHALL have ports rd_data_valid out 1, rd_data_ready in 1, rd_data out DATA_WIDTH and rd_last out 1, meaning the read data toward the reader.
REQ-012 The block SHALL have ports busy out 1 and err out 2, meaning busy = state not IDLE, err[0] = write underrun, err[1] = unexpected read data.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WR_DATA and RD_WAIT.
REQ-014 cmd_ready SHALL be 1 only in IDLE, and then only when cmd_data.rw==WRITE_CMD or the read FIFO has >= BURST_LEN free entries.
REQ-015 On cmd_valid&&cmd_ready, rw, addr and auto_precharge_en SHALL be latched; the next state is ISSUE.
REQ-016 In ISSUE, ctrl_req SHALL be 1 and ctrl_rw/addr/ap SHALL be held stable until ctrl_ack; ack in the same cycle as the req rising edge is legal.
REQ-017 On ctrl_ack, the next state SHALL be WR_DATA for writes and RD_WAIT for reads, and the beat counter SHALL be cleared.
REQ-018 In WR_DATA, wr_data_ready SHALL equal ctrl_wdata_req, and ctrl_wdata SHALL equal wr_data combinationally.
REQ-019 In WR_DATA, each ctrl_wdata_req SHALL count one beat; after beat BURST_LEN-1 the next state is IDLE.
REQ-020 If ctrl_wdata_req=1 and wr_data_valid=0, then ctrl_wdata SHALL be 0, the beat still counts, and err[0] SHALL be set sticky.
REQ-021 In RD_WAIT, each ctrl_rdata_valid SHALL push ctrl_rdata into the read FIFO and count one beat; after beat BURST_LEN-1 the next state is IDLE.
REQ-022 ctrl_rdata_valid outside RD_WAIT, or with the FIFO full, SHALL drop the word and set err[1] sticky.
REQ-023 The read FIFO SHALL have depth 2*BURST_LEN, be first-word-fall-through, with rd_data_valid = not empty; a pop occurs on rd_data_valid&&rd_data_ready.
REQ-024 A push and a pop in the same cycle SHALL be allowed, including when the FIFO is full or empty-with-bypass; pointers SHALL wrap modulo the depth.
REQ-025 rd_last SHALL be 1 on every BURST_LEN-th popped word, using a pop counter that wraps at BURST_LEN.
REQ-026 Outside ISSUE, ctrl_req SHALL be 0; outside WR_DATA, wr_data_ready SHALL be 0.

Reset
REQ-027 rst SHALL force IDLE and clear the FIFO pointers, beat counter, pop counter and err, regardless of any burst in flight.
REQ-028 During and after reset, cmd_ready=0 (while rst=1), ctrl_req=0, wr_data_ready=0, rd_data_valid=0, rd_last=0, busy=0, err=0, and ctrl_addr/ctrl_wdata/rd_data=0.

Configuration
REQ-029 With SDRAM_DISPATCH_STATS_EN defined, the ports stat_rd_bursts and stat_wr_bursts (out, 32) SHALL exist; each increments, saturating, at its burst completion and is cleared by rst.
REQ-030 Without SDRAM_DISPATCH_STATS_EN, those ports and their counters SHALL be absent, and the behaviour SHALL otherwise be identical.

Structure
REQ-031 sdram_pkg SHALL hold sdram_cmd_t, READ_CMD/WRITE_CMD and the dispatcher state enum.
REQ-032 The read FIFO SHALL be the sub-module sdram_rd_fifo (parameters DATA_WIDTH and DEPTH).

Verification
REQ-033 Read to addr 0x000100, controller acks after 3 cycles, returns 8 words 0xA0..0xA7 with rd_data_ready=1 -> reader receives 0xA0..0xA7 in order, with rd_last only on 0xA7.
REQ-034 Write to addr 0x000200 with wr_data valid 0x10..0x17 -> ctrl_wdata delivers 0x10..0x17 on 8 ctrl_wdata_req cycles, err=0, and the block returns to IDLE.
REQ-035 Two reads with rd_data_ready=0 -> both are accepted (16 entries); a third read sees cmd_ready=0 until one word is popped... then stays 0 until 8 words are free.
REQ-036 Write with wr_data_valid dropped at beat 4 -> ctrl_wdata=0 at beat 4 and err[0]=1 until rst.
REQ-037 ctrl_rdata_valid pulse while in IDLE -> FIFO is unchanged and err[1]=1; rst asserted mid-RD_WAIT (beat 3) -> the next cycle is IDLE with an empty FIFO and err=0.
